// File: rtl/ht_task_gen.sv
// ht_task_gen -- programmable SEARCH/INSERT/DELETE traffic source and result
// tally for hash_table_top.
//
// A start pulse latches mode, op count and key base, then tasks are issued
// under valid/ready flow control with at most MAX_OUTSTANDING tasks awaiting
// a result. Returned results are counted (total and "found").
//
// Optional feature macro: HT_TASK_GEN_TIMEOUT_EN
//   defined   : a watchdog ends a stalled run after TIMEOUT idle cycles and
//               raises timeout_o until the next start.
//   undefined : no watchdog, timeout_o tied low, DRAIN waits indefinitely.

package ht_task_gen_pkg;

   // Command encoding presented on the task interface.
   typedef enum logic [1:0] {
      CMD_SEARCH = 2'd0,
      CMD_INSERT = 2'd1,
      CMD_DELETE = 2'd2
   } ht_cmd_t;

   // Traffic modes selected by mode_i.
   typedef enum logic [1:0] {
      MODE_SEQ_INSERT  = 2'd0,
      MODE_SEQ_SEARCH  = 2'd1,
      MODE_RAND_SEARCH = 2'd2,
      MODE_MIXED       = 2'd3
   } ht_mode_t;

endpackage

module ht_task_gen
   import ht_task_gen_pkg::*;
#(
   parameter int          KEY_WIDTH       = 32,
   parameter int          VALUE_WIDTH     = 16,
   parameter int          CNT_WIDTH       = 16,
   parameter int          MAX_OUTSTANDING = 4,
   parameter logic [31:0] LFSR_SEED       = 32'hACE1_2468,
   parameter int          TIMEOUT         = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [1:0]             mode_i,
   input  logic [CNT_WIDTH-1:0]   num_ops_i,
   input  logic [KEY_WIDTH-1:0]   key_base_i,
   output logic [KEY_WIDTH-1:0]   task_key_o,
   output logic [VALUE_WIDTH-1:0] task_value_o,
   output ht_cmd_t                task_cmd_o,
   output logic                   task_valid_o,
   input  logic                   task_ready_i,
   input  logic                   res_valid_i,
   output logic                   res_ready_o,
   input  logic                   res_found_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   timeout_o,
   output logic [CNT_WIDTH-1:0]   sent_cnt_o,
   output logic [CNT_WIDTH-1:0]   rcvd_cnt_o,
   output logic [CNT_WIDTH-1:0]   found_cnt_o
);

   // Elaboration-time parameter sanity checks.
   if (KEY_WIDTH < 1 || KEY_WIDTH > 32) begin : g_bad_key_width
      $error("ht_task_gen: KEY_WIDTH must be 1..32");
   end
   if (VALUE_WIDTH < 1 || VALUE_WIDTH > 32) begin : g_bad_value_width
      $error("ht_task_gen: VALUE_WIDTH must be 1..32");
   end
   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255) begin : g_bad_max_out
      $error("ht_task_gen: MAX_OUTSTANDING must be 1..255");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("ht_task_gen: TIMEOUT must be at least 1");
   end
   if (LFSR_SEED == 32'h0) begin : g_bad_seed
      $error("ht_task_gen: LFSR_SEED must be non-zero");
   end

   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [KEY_WIDTH-1:0]   key;
      logic [VALUE_WIDTH-1:0] value;
      ht_cmd_t                cmd;
   } payload_t;

   state_t                 state_q;
   ht_mode_t               mode_q;
   logic [CNT_WIDTH-1:0]   num_ops_q;
   logic [KEY_WIDTH-1:0]   key_base_q;
   logic [CNT_WIDTH-1:0]   idx_q;
   logic [31:0]            lfsr_q;
   logic [7:0]             outstanding_q;

   logic                   run_active;
   logic                   start_take;
   logic                   accept;
   logic                   result;
   logic                   last_accept;
   logic                   drain_done;
   logic                   wd_fire;
   logic                   room_next;
   logic [31:0]            lfsr_next;
   logic [7:0]             outstanding_next;
   logic [CNT_WIDTH-1:0]   idx_next;
   payload_t               pay_first;
   payload_t               pay_next;

   // Task payload for op index i in mode m.
   function automatic payload_t build_payload(
      input ht_mode_t               m,
      input logic [KEY_WIDTH-1:0]   base,
      input logic [CNT_WIDTH-1:0]   i,
      input logic [31:0]            l
   );
      payload_t p;
      p.key   = base + KEY_WIDTH'(i);
      p.value = '0;
      p.cmd   = CMD_SEARCH;
      unique case (m)
         MODE_SEQ_INSERT: begin
            p.cmd   = CMD_INSERT;
            p.value = VALUE_WIDTH'(i);
         end
         MODE_SEQ_SEARCH: begin
            p.cmd   = CMD_SEARCH;
         end
         MODE_RAND_SEARCH: begin
            p.key   = l[KEY_WIDTH-1:0];
         end
         MODE_MIXED: begin
            p.key   = l[KEY_WIDTH-1:0];
            p.value = l[31 -: VALUE_WIDTH];
            unique case (l[1:0])
               2'b10:   p.cmd = CMD_INSERT;
               2'b11:   p.cmd = CMD_DELETE;
               default: p.cmd = CMD_SEARCH;
            endcase
         end
      endcase
      return p;
   endfunction

   // Handshake decode, LFSR step, outstanding bookkeeping and next payloads.
   always_comb begin
      run_active  = (state_q == ST_SEND) || (state_q == ST_DRAIN);
      start_take  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      accept      = task_valid_o && task_ready_i;
      result      = res_valid_i && run_active;
      last_accept = accept && (idx_q == (num_ops_q - CNT_WIDTH'(1)));
      drain_done  = (state_q == ST_DRAIN) && (rcvd_cnt_o == sent_cnt_o);
      idx_next    = idx_q + CNT_WIDTH'(1);

      lfsr_next = {1'b0, lfsr_q[31:1]};
      if (lfsr_q[0]) begin
         lfsr_next = lfsr_next ^ LFSR_MASK;
      end

      // Result with nothing outstanding is still counted but cannot underflow.
      outstanding_next = outstanding_q;
      if (accept && !result) begin
         outstanding_next = outstanding_q + 8'd1;
      end else if (result && !accept && (outstanding_q != 8'd0)) begin
         outstanding_next = outstanding_q - 8'd1;
      end
      room_next = int'(outstanding_next) < MAX_OUTSTANDING;

      pay_first = build_payload(ht_mode_t'(mode_i), key_base_i, '0, LFSR_SEED);
      pay_next  = build_payload(mode_q, key_base_q, idx_next, lfsr_next);
   end

`ifdef HT_TASK_GEN_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_q;
   logic            timeout_q;

   // Fires after TIMEOUT consecutive cycles without accept or result.
   always_comb begin
      wd_fire = run_active && !accept && !result && !drain_done &&
                (wd_q == WD_W'(TIMEOUT - 1));
   end

   // Watchdog counter and sticky timeout flag, cleared by start.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else if (start_take) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else if (run_active) begin
         if (accept || result || wd_fire) begin
            wd_q <= '0;
         end else begin
            wd_q <= wd_q + WD_W'(1);
         end
         if (wd_fire) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign timeout_o = timeout_q;
`else
   assign wd_fire   = 1'b0;
   assign timeout_o = 1'b0;
`endif

   assign res_ready_o = 1'b1;

   // Statistics counters and outstanding count, live only during a run.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         sent_cnt_o    <= '0;
         rcvd_cnt_o    <= '0;
         found_cnt_o   <= '0;
         outstanding_q <= '0;
      end else if (start_take) begin
         sent_cnt_o    <= '0;
         rcvd_cnt_o    <= '0;
         found_cnt_o   <= '0;
         outstanding_q <= '0;
      end else if (run_active) begin
         outstanding_q <= outstanding_next;
         if (accept && (sent_cnt_o != '1)) begin
            sent_cnt_o <= sent_cnt_o + CNT_WIDTH'(1);
         end
         if (result && (rcvd_cnt_o != '1)) begin
            rcvd_cnt_o <= rcvd_cnt_o + CNT_WIDTH'(1);
         end
         if (result && res_found_i && (found_cnt_o != '1)) begin
            found_cnt_o <= found_cnt_o + CNT_WIDTH'(1);
         end
      end
   end

   // Control FSM with registered valid, busy, done and payload outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_SEQ_INSERT;
         num_ops_q    <= '0;
         key_base_q   <= '0;
         idx_q        <= '0;
         lfsr_q       <= LFSR_SEED;
         task_valid_o <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         task_key_o   <= '0;
         task_value_o <= '0;
         task_cmd_o   <= CMD_SEARCH;
      end else begin
         done_o <= 1'b0;
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  mode_q     <= ht_mode_t'(mode_i);
                  num_ops_q  <= num_ops_i;
                  key_base_q <= key_base_i;
                  idx_q      <= '0;
                  lfsr_q     <= LFSR_SEED;
                  if (num_ops_i == '0) begin
                     state_q      <= ST_DONE;
                     task_valid_o <= 1'b0;
                     busy_o       <= 1'b0;
                     done_o       <= 1'b1;
                  end else begin
                     state_q      <= ST_SEND;
                     task_valid_o <= 1'b1;
                     busy_o       <= 1'b1;
                     task_key_o   <= pay_first.key;
                     task_value_o <= pay_first.value;
                     task_cmd_o   <= pay_first.cmd;
                  end
               end
            end

            ST_SEND: begin
               if (wd_fire) begin
                  state_q      <= ST_DONE;
                  task_valid_o <= 1'b0;
                  busy_o       <= 1'b0;
                  done_o       <= 1'b1;
               end else if (accept) begin
                  idx_q        <= idx_next;
                  lfsr_q       <= lfsr_next;
                  task_key_o   <= pay_next.key;
                  task_value_o <= pay_next.value;
                  task_cmd_o   <= pay_next.cmd;
                  if (last_accept) begin
                     state_q      <= ST_DRAIN;
                     task_valid_o <= 1'b0;
                  end else begin
                     task_valid_o <= room_next;
                  end
               end else begin
                  // Without an accept the outstanding count cannot grow, so a
                  // raised valid is never withdrawn here.
                  task_valid_o <= room_next;
               end
            end

            ST_DRAIN: begin
               if (drain_done || wd_fire) begin
                  state_q <= ST_DONE;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ht_task_gen.md
# ht_task_gen

Synthesizable stimulus generator and result tally for `hash_table_top`. It drives the `ht_task_if` side with a programmable burst of SEARCH/INSERT/DELETE commands under valid/ready flow control, and counts the responses returned on `ht_res_if`. It generalises the fixed-sequence bench stimulus into a parametrised, on-chip traffic source for hardware bring-up and throughput measurement.

## Interface
Parameters:
- `KEY_WIDTH`, 32: key width; must be ≤ 32.
- `VALUE_WIDTH`, 16: value width.
- `CNT_WIDTH`, 16: width of the op count and the statistics counters.
- `MAX_OUTSTANDING`, 4: maximum number of accepted tasks without a result (1..255).
- `LFSR_SEED`, 32'hACE1_2468: non-zero seed loaded on start.
- `TIMEOUT`, 1024: watchdog cycles; used only with `HT_TASK_GEN_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk_i`, in, 1: the only clock.
- `rst_i`, in, 1: reset; synchronous, active-low.
- `start_i`, in, 1: one-cycle start pulse; ignored unless in IDLE or DONE.
- `mode_i`, in, 2: 0 SEQ_INSERT, 1 SEQ_SEARCH, 2 RAND_SEARCH, 3 MIXED; sampled on start.
- `num_ops_i`, in, CNT_WIDTH: tasks to issue; sampled on start.
- `key_base_i`, in, KEY_WIDTH: first key for the sequential modes; sampled on start.
- `task_key_o`, out, KEY_WIDTH: task key.
- `task_value_o`, out, VALUE_WIDTH: task value.
- `task_cmd_o`, out, `ht_cmd_t`: task command.
- `task_valid_o`, out, 1: task valid.
- `task_ready_i`, in, 1: task ready.
- `res_valid_i`, in, 1: result valid.
- `res_ready_o`, out, 1: result ready; constant 1.
- `res_found_i`, in, 1: the result reports the key present or the operation successful.
- `busy_o`, out, 1: high in SEND and DRAIN.
- `done_o`, out, 1: one-cycle pulse on entry to DONE.
- `timeout_o`, out, 1: the run ended by watchdog.
- `sent_cnt_o`, out, CNT_WIDTH: tasks accepted.
- `rcvd_cnt_o`, out, CNT_WIDTH: results received.
- `found_cnt_o`, out, CNT_WIDTH: results with `res_found_i` high.

## Operation
- FSM states: IDLE, SEND, DRAIN, DONE.
- IDLE/DONE → SEND on `start_i`. The start pulse:
  - clears all counters and `timeout_o`;
  - loads the LFSR with `LFSR_SEED`;
  - sets the op index to 0;
  - latches `mode_i`, `num_ops_i` and `key_base_i`.
- If `num_ops_i` is 0, the FSM goes directly to DONE (`done_o` pulses, nothing is sent).
- SEND:
  - `task_valid_o` is high whenever outstanding < `MAX_OUTSTANDING`.
  - A task is accepted on a cycle where `task_valid_o` and `task_ready_i` are both high.
  - On acceptance: `sent_cnt_o`++, op index++, LFSR steps once.
  - After the last acceptance the FSM moves to DRAIN.
- DRAIN → DONE when `rcvd_cnt_o == sent_cnt_o`.
- Outstanding count = accepts − results.
  - A simultaneous accept and result leaves it unchanged.
  - A result arriving with outstanding = 0 is still counted, and outstanding saturates at 0.
- Payload per mode (i is the op index):
  - SEQ_INSERT: cmd INSERT, key = base + i (modulo 2^KEY_WIDTH), value = i[VALUE_WIDTH-1:0].
  - SEQ_SEARCH: cmd SEARCH, key = base + i, value 0.
  - RAND_SEARCH: cmd SEARCH, key = lfsr[KEY_WIDTH-1:0], value 0.
  - MIXED: key = lfsr[KEY_WIDTH-1:0], value = lfsr[31:32-VALUE_WIDTH]; cmd from lfsr[1:0]: 00/01 SEARCH, 10 INSERT, 11 DELETE.
- LFSR: 32-bit Galois, mask 32'h8020_0003, shifts right.
- Payload stability: payload and `task_valid_o` stay stable while valid is high and ready is low. Valid never drops without an accept.
- All counters saturate at all-ones.

## Timing
- Reset values (on `rst_i` low at a clock edge):
  - state IDLE;
  - `task_valid_o`, `busy_o`, `done_o`, `timeout_o` all 0;
  - all counters 0;
  - `task_key_o`, `task_value_o` 0; `task_cmd_o` SEARCH;
  - `res_ready_o` 1.
- Reset in mid-run aborts immediately. There is no `done_o` pulse.
- `start_i` → `task_valid_o` high on the next cycle (1-cycle latency).
- With `task_ready_i` held high and results returning, the block sustains one task per cycle.
- `done_o` rises the cycle after the final result is counted. `busy_o` is low in that same cycle.
- All outputs are registered.

## Configuration
- `HT_TASK_GEN_TIMEOUT_EN`, defined: a watchdog counts cycles in SEND/DRAIN with no accept and no result.
  - It clears on either event.
  - At `TIMEOUT` it forces DONE, pulses `done_o` and sets `timeout_o`, which holds until the next start.
- Not defined: no watchdog logic is compiled, `timeout_o` is tied to 0, and DRAIN waits indefinitely.

## Test plan
- Start SEQ_INSERT with num_ops = 5, base 32'h0100_0000, ready and result echo held high → keys 0100_0000..0100_0004, values 0..4, `done_o` pulses, sent = rcvd = 5.
- SEQ_SEARCH with num_ops = 3, `res_found_i` alternating 1,0,1 → found_cnt 2.
- RAND_SEARCH with `task_ready_i` low for 10 cycles → key and valid stable throughout; the first key equals the seed-derived LFSR value; no transfer is lost.
- MAX_OUTSTANDING = 4 with results withheld → exactly 4 accepts, then valid low; releasing 1 result → exactly 1 more accept.
- num_ops = 0 → `done_o` on the cycle after start, sent 0. A reset asserted mid-run at sent = 2 → all outputs return to reset values with no `done_o`.
- With `HT_TASK_GEN_TIMEOUT_EN` and TIMEOUT = 16, results never returned → DONE 16 cycles after the last accept with `timeout_o` = 1.
